// File: rtl/sync_mod_counter.sv
// ---------------------------------------------------------------------------
// sync_mod_counter
//
// Purpose:
//   Parametrised synchronous modulo-N up/down counter. The count runs
//   0..MODULUS-1 in either direction, with synchronous clear, parallel load
//   and a count enable. A combinational terminal count lets several stages
//   be chained (tc of one stage into en of the next) so that all stages
//   advance on the same edge. A registered wrap pulse and a sticky
//   out-of-range load flag are provided for downstream logic.
//
// Parameters:
//   WIDTH       counter width in bits (2..16)
//   MODULUS     sequence length (2..2**WIDTH)
//   RESET_VALUE count value after rst (must be < MODULUS)
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active-high
//   clr       in   synchronous clear to 0 (highest priority)
//   load      in   synchronous parallel load
//   load_val  in   value taken on load (clamped to MODULUS-1 if too large)
//   en        in   count enable (cascade input)
//   up        in   direction, 1 = increment, 0 = decrement
//   count     out  registered counter state
//   tc        out  combinational terminal count
//   wrap      out  registered pulse following a wrap
//   load_err  out  sticky flag, an out-of-range load was seen
// ---------------------------------------------------------------------------
module sync_mod_counter #(
   parameter int WIDTH       = 4,
   parameter int MODULUS     = 10,
   parameter int RESET_VALUE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);

   // MODULUS-1 is kept as a WIDTH-bit constant so that MODULUS == 2**WIDTH
   // never needs a WIDTH+1 bit comparison on the count path.
   localparam logic [WIDTH-1:0] LAST_VAL  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_VAL   = WIDTH'(RESET_VALUE);
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
   // The load range check is the only place that needs the full modulus,
   // so it is done one bit wider.
   localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             loadErr_q, loadErr_d;

   logic             atTop;
   logic             atBottom;
   logic             wrapEvent;
   logic             loadInRange;

   // Boundary detection and the wrap condition shared by tc and wrap.
   always_comb begin
      atTop       = (count_q == LAST_VAL);
      atBottom    = (count_q == '0);
      wrapEvent   = en && (up ? atTop : atBottom);
      loadInRange = ({1'b0, load_val} < MOD_EXT);
   end

   // Terminal count is unregistered so a downstream stage sees it in the
   // same cycle; clear and load suppress it because they win over counting.
   always_comb begin
      tc = wrapEvent && !clr && !load;
   end

   // Next-state selection in priority order clr > load > en > hold.
   // When the stage is not enabled wrap holds its value, so in a cascade a
   // higher stage keeps its flag until its next enabled edge.
   always_comb begin
      count_d   = count_q;
      wrap_d    = wrap_q;
      loadErr_d = loadErr_q;
      if (clr) begin
         count_d   = '0;
         wrap_d    = 1'b0;
         loadErr_d = 1'b0;
      end else if (load) begin
         wrap_d = 1'b0;
         if (loadInRange) begin
            count_d = load_val;
         end else begin
            count_d   = LAST_VAL;
            loadErr_d = 1'b1;
         end
      end else if (en) begin
         wrap_d = wrapEvent;
         if (up) begin
            count_d = atTop ? '0 : (count_q + ONE);
         end else begin
            count_d = atBottom ? LAST_VAL : (count_q - ONE);
         end
      end
   end

   // State register with asynchronous reset to the configured start value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= RST_VAL;
         wrap_q    <= 1'b0;
         loadErr_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         wrap_q    <= wrap_d;
         loadErr_q <= loadErr_d;
      end
   end

   // Registered state drives the outputs directly.
   always_comb begin
      count    = count_q;
      wrap     = wrap_q;
      load_err = loadErr_q;
   end

endmodule

// File: tb/tb_sync_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_sync_mod_counter
//
// Drives a decade counter and a modulo-16 counter from the same directed and
// random stimulus and compares both against an arithmetic reference model.
// A two-stage decade cascade is then run through a full 00..99 cycle.
// ---------------------------------------------------------------------------
module tb_sync_mod_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr;
   logic       load;
   logic [3:0] loadVal;
   logic       en;
   logic       up;

   logic [3:0] count10, count16;
   logic       tc10, wrap10, err10;
   logic       tc16, wrap16, err16;

   logic       cascEn;
   logic [3:0] onesCount, tensCount;
   logic       onesTc, tensTc, onesWrap, tensWrap, onesErr, tensErr;

   int total = 0;
   int bad   = 0;

   // Reference model state for the two directly driven instances.
   int m10Count, m16Count;
   bit m10Wrap, m16Wrap, m10Err, m16Err;

   always #5 clk = ~clk;

   sync_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dut10 (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(loadVal),
      .en(en), .up(up), .count(count10), .tc(tc10), .wrap(wrap10),
      .load_err(err10));

   sync_mod_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) dut16 (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(loadVal),
      .en(en), .up(up), .count(count16), .tc(tc16), .wrap(wrap16),
      .load_err(err16));

   sync_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) ones (
      .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .load_val(4'd0),
      .en(cascEn), .up(1'b1), .count(onesCount), .tc(onesTc),
      .wrap(onesWrap), .load_err(onesErr));

   sync_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) tens (
      .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .load_val(4'd0),
      .en(onesTc), .up(1'b1), .count(tensCount), .tc(tensTc),
      .wrap(tensWrap), .load_err(tensErr));

   // One comparison: counts it, reports it on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Behavioural model of one clock edge for a modulo-m counter.
   task automatic modelEdge(input int m, input bit c, input bit l, input int lv,
                            input bit e, input bit u,
                            inout int cnt, inout bit w, inout bit er);
      if (c) begin
         cnt = 0; w = 1'b0; er = 1'b0;
      end else if (l) begin
         w = 1'b0;
         if (lv < m) cnt = lv;
         else begin
            cnt = m - 1; er = 1'b1;
         end
      end else if (e) begin
         if (u) begin
            w   = (cnt == m - 1);
            cnt = (cnt + 1) % m;
         end else begin
            w   = (cnt == 0);
            cnt = (cnt + m - 1) % m;
         end
      end
   endtask

   function automatic bit modelTc(input int m, input int cnt, input bit c,
                                  input bit l, input bit e, input bit u);
      return e && !c && !l && ((u && cnt == m - 1) || (!u && cnt == 0));
   endfunction

   task automatic modelReset();
      m10Count = 0; m10Wrap = 1'b0; m10Err = 1'b0;
      m16Count = 0; m16Wrap = 1'b0; m16Err = 1'b0;
   endtask

   task automatic checkState();
      checkOutput("count10", 32'(count10), 32'(m10Count));
      checkOutput("wrap10",  32'(wrap10),  32'(m10Wrap));
      checkOutput("err10",   32'(err10),   32'(m10Err));
      checkOutput("count16", 32'(count16), 32'(m16Count));
      checkOutput("wrap16",  32'(wrap16),  32'(m16Wrap));
      checkOutput("err16",   32'(err16),   32'(m16Err));
   endtask

   // Drive one cycle of inputs, check tc before the edge and state after.
   task automatic applyStimulus(input bit c, input bit l, input int lv,
                                input bit e, input bit u);
      clr = c; load = l; loadVal = 4'(lv); en = e; up = u;
      #1;
      checkOutput("tc10", 32'(tc10), 32'(modelTc(10, m10Count, c, l, e, u)));
      checkOutput("tc16", 32'(tc16), 32'(modelTc(16, m16Count, c, l, e, u)));
      @(posedge clk);
      modelEdge(10, c, l, lv, e, u, m10Count, m10Wrap, m10Err);
      modelEdge(16, c, l, lv, e, u, m16Count, m16Wrap, m16Err);
      #1;
      checkState();
   endtask

   initial begin
      int v;
      bit oW, tW;
      rst = 1'b1; clr = 1'b0; load = 1'b0; loadVal = 4'd0;
      en = 1'b0; up = 1'b1; cascEn = 1'b0;
      modelReset();
      #1;
      $display("[TB] reset state");
      checkState();
      checkOutput("ones_rst", 32'(onesCount), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] up count through wrap");
      repeat (12) applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1);

      $display("[TB] down count through wrap");
      applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0);

      $display("[TB] loads and sticky error");
      applyStimulus(1'b0, 1'b1, 6, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 12, 1'b0, 1'b1);
      repeat (4) applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b1);

      $display("[TB] priority");
      applyStimulus(1'b0, 1'b1, 5, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 9, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 3, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 7, 1'b1, 1'b1);

      $display("[TB] asynchronous reset mid-count");
      clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1;
      #2 rst = 1'b1;
      modelReset();
      #1;
      checkState();
      #2 rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1);

      $display("[TB] full-range load and natural wrap");
      applyStimulus(1'b0, 1'b1, 15, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0);

      $display("[TB] random stimulus");
      for (int i = 0; i < 400; i++) begin
         bit c, l, e, u;
         int lv;
         c  = ($urandom_range(0, 19) == 0);
         l  = ($urandom_range(0, 7) == 0);
         e  = ($urandom_range(0, 3) != 0);
         u  = ($urandom_range(0, 1) == 1);
         lv = int'($urandom_range(0, 15));
         applyStimulus(c, l, lv, e, u);
      end
      en = 1'b0; clr = 1'b0; load = 1'b0;

      $display("[TB] two-stage decade cascade");
      v = 0; oW = 1'b0; tW = 1'b0;
      cascEn = 1'b1;
      for (int i = 0; i < 105; i++) begin
         #1;
         checkOutput("ones_tc", 32'(onesTc), 32'((v % 10) == 9));
         checkOutput("tens_tc", 32'(tensTc), 32'(v == 99));
         @(posedge clk);
         oW = ((v % 10) == 9);
         if ((v % 10) == 9) tW = (v == 99);
         v = (v + 1) % 100;
         #1;
         checkOutput("ones_count", 32'(onesCount), 32'(v % 10));
         checkOutput("tens_count", 32'(tensCount), 32'(v / 10));
         checkOutput("ones_wrap",  32'(onesWrap),  32'(oW));
         checkOutput("tens_wrap",  32'(tensWrap),  32'(tW));
      end
      cascEn = 1'b0;
      checkOutput("ones_err", 32'(onesErr), 32'd0);
      checkOutput("tens_err", 32'(tensErr), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
